// File: rtl/pipe_pkg.sv
// Shared types for the operand forwarding / load-use hazard unit:
// forward-select encodings, the per-stage control tag and the stall FSM states.
package pipe_pkg;

    localparam logic [1:0] FWD_RF    = 2'b00;
    localparam logic [1:0] FWD_EXMEM = 2'b10;
    localparam logic [1:0] FWD_MEMWB = 2'b01;
    localparam logic [1:0] FWD_RET   = 2'b11;

    typedef struct packed {
        logic valid;
        logic reg_write;
        logic mem_read;
    } stage_tag_t;

    localparam stage_tag_t TAG_NONE = '{valid: 1'b0, reg_write: 1'b0, mem_read: 1'b0};

    typedef enum logic [0:0] {
        ST_IDLE    = 1'b0,
        ST_STALLED = 1'b1
    } hz_state_e;

endpackage

// File: rtl/fwd_hazard_unit_if.sv
// Decode-stage tags, bypass data and hazard/forwarding results exchanged
// between the pipeline datapath (master) and the hazard unit (slave).
interface fwd_hazard_unit_if #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32
);
    logic              hold;
    logic              flush;
    logic              id_valid;
    logic [ADDR_W-1:0] id_rs;
    logic [ADDR_W-1:0] id_rt;
    logic              id_uses_rs;
    logic              id_uses_rt;
    logic              id_reg_write;
    logic              id_mem_read;
    logic [ADDR_W-1:0] id_dst;
    logic [DATA_W-1:0] ex_rs_data;
    logic [DATA_W-1:0] ex_rt_data;
    logic [DATA_W-1:0] ex_mem_alu_result;
    logic [DATA_W-1:0] mem_wb_write_data;
    logic              stall;
    logic              bubble;
    logic [1:0]        forward_a;
    logic [1:0]        forward_b;
    logic [DATA_W-1:0] operand_a;
    logic [DATA_W-1:0] operand_b;

    modport master (
        output hold, flush, id_valid, id_rs, id_rt, id_uses_rs, id_uses_rt,
               id_reg_write, id_mem_read, id_dst, ex_rs_data, ex_rt_data,
               ex_mem_alu_result, mem_wb_write_data,
        input  stall, bubble, forward_a, forward_b, operand_a, operand_b
    );

    modport slave (
        input  hold, flush, id_valid, id_rs, id_rt, id_uses_rs, id_uses_rt,
               id_reg_write, id_mem_read, id_dst, ex_rs_data, ex_rt_data,
               ex_mem_alu_result, mem_wb_write_data,
        output stall, bubble, forward_a, forward_b, operand_a, operand_b
    );
endinterface

// File: rtl/fwd_select.sv
// Priority forward select and operand mux for one ALU source operand.
module fwd_select
    import pipe_pkg::*;
#(
    parameter int ADDR_W    = 5,
    parameter int DATA_W    = 32,
    parameter int WB_BYPASS = 1
) (
    input  logic              ex_valid,
    input  logic              uses,
    input  logic [ADDR_W-1:0] src,
    input  stage_tag_t        mem_tag,
    input  logic [ADDR_W-1:0] mem_dst,
    input  logic              wb_valid,
    input  logic              wb_reg_write,
    input  logic [ADDR_W-1:0] wb_dst,
    input  logic              ret_valid,
    input  logic [ADDR_W-1:0] ret_dst,
    input  logic [DATA_W-1:0] rf_data,
    input  logic [DATA_W-1:0] exmem_data,
    input  logic [DATA_W-1:0] memwb_data,
    input  logic [DATA_W-1:0] ret_data,
    output logic [1:0]        sel,
    output logic [DATA_W-1:0] operand
);

    localparam logic [ADDR_W-1:0] REG_ZERO = {ADDR_W{1'b0}};

    logic mem_hit;
    logic wb_hit;
    logic ret_hit;

    // Youngest producer wins; a load still in MEM has no data yet, so it falls through
    always_comb begin
        mem_hit = mem_tag.valid && mem_tag.reg_write && (mem_dst != REG_ZERO) && (mem_dst == src);
        wb_hit  = wb_valid && wb_reg_write && (wb_dst != REG_ZERO) && (wb_dst == src);
        ret_hit = (WB_BYPASS != 0) && ret_valid && (ret_dst != REG_ZERO) && (ret_dst == src);
        sel     = FWD_RF;
        if (!ex_valid || !uses) begin
            sel = FWD_RF;
        end else if (mem_hit && !mem_tag.mem_read) begin
            sel = FWD_EXMEM;
        end else if (wb_hit) begin
            sel = FWD_MEMWB;
        end else if (ret_hit) begin
            sel = FWD_RET;
        end else begin
            sel = FWD_RF;
        end
    end

    // Operand mux driven by the select above
    always_comb begin
        operand = rf_data;
        case (sel)
            FWD_EXMEM: operand = exmem_data;
            FWD_MEMWB: operand = memwb_data;
            FWD_RET:   operand = ret_data;
            default:   operand = rf_data;
        endcase
    end

endmodule

// File: rtl/fwd_hazard_unit.sv
// Operand forwarding and load-use hazard controller with a private shadow
// tag pipeline (EX, MEM, WB, RET) fed from decode-stage tags.
module fwd_hazard_unit
    import pipe_pkg::*;
#(
    parameter int ADDR_W    = 5,
    parameter int DATA_W    = 32,
    parameter int WB_BYPASS = 1
) (
    input logic              clk,
    input logic              reset,
    fwd_hazard_unit_if.slave bus
);

    localparam logic [ADDR_W-1:0] REG_ZERO  = {ADDR_W{1'b0}};
    localparam logic [DATA_W-1:0] DATA_ZERO = {DATA_W{1'b0}};

    hz_state_e         state_q, state_d;
    stage_tag_t        ex_tag_q, ex_tag_d, mem_tag_q, mem_tag_d;
    logic              ex_uses_rs_q, ex_uses_rs_d, ex_uses_rt_q, ex_uses_rt_d;
    logic [ADDR_W-1:0] ex_rs_q, ex_rs_d, ex_rt_q, ex_rt_d, ex_dst_q, ex_dst_d;
    logic [ADDR_W-1:0] mem_dst_q, mem_dst_d, wb_dst_q, wb_dst_d, ret_dst_q, ret_dst_d;
    logic              wb_valid_q, wb_valid_d, wb_reg_write_q, wb_reg_write_d;
    logic              ret_valid_q, ret_valid_d;
    logic [DATA_W-1:0] ret_data_q, ret_data_d;
    logic              load_use;
    logic              stall;

    // Load-use detect and one-shot stall FSM; flush and hold both suppress the stall
    always_comb begin
        load_use = bus.id_valid && ex_tag_q.valid && ex_tag_q.mem_read && (ex_dst_q != REG_ZERO)
                   && ((bus.id_uses_rs && (bus.id_rs == ex_dst_q))
                    || (bus.id_uses_rt && (bus.id_rt == ex_dst_q)));
        state_d  = state_q;
        stall    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (load_use && !bus.flush && !bus.hold) begin
                    stall   = 1'b1;
                    state_d = ST_STALLED;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_STALLED: begin
                if (bus.hold) begin
                    state_d = ST_STALLED;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Shadow tag pipeline advance; everything holds while the pipeline is frozen
    always_comb begin
        ex_tag_d       = ex_tag_q;
        ex_uses_rs_d   = ex_uses_rs_q;
        ex_uses_rt_d   = ex_uses_rt_q;
        ex_rs_d        = ex_rs_q;
        ex_rt_d        = ex_rt_q;
        ex_dst_d       = ex_dst_q;
        mem_tag_d      = mem_tag_q;
        mem_dst_d      = mem_dst_q;
        wb_valid_d     = wb_valid_q;
        wb_reg_write_d = wb_reg_write_q;
        wb_dst_d       = wb_dst_q;
        ret_valid_d    = ret_valid_q;
        ret_dst_d      = ret_dst_q;
        ret_data_d     = ret_data_q;
        if (!bus.hold) begin
            ex_tag_d.valid     = bus.id_valid && !bus.flush && !stall;
            ex_tag_d.reg_write = bus.id_reg_write;
            ex_tag_d.mem_read  = bus.id_mem_read;
            ex_uses_rs_d       = bus.id_uses_rs;
            ex_uses_rt_d       = bus.id_uses_rt;
            ex_rs_d            = bus.id_rs;
            ex_rt_d            = bus.id_rt;
            ex_dst_d           = bus.id_dst;
            mem_tag_d          = ex_tag_q;
            mem_dst_d          = ex_dst_q;
            wb_valid_d         = mem_tag_q.valid;
            wb_reg_write_d     = mem_tag_q.reg_write;
            wb_dst_d           = mem_dst_q;
            ret_valid_d        = wb_valid_q && wb_reg_write_q && (wb_dst_q != REG_ZERO);
            ret_dst_d          = wb_dst_q;
            ret_data_d         = bus.mem_wb_write_data;
        end else begin
            ret_data_d = ret_data_q;
        end
    end

    // State registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= ST_IDLE;
            ex_tag_q       <= TAG_NONE;
            ex_uses_rs_q   <= 1'b0;
            ex_uses_rt_q   <= 1'b0;
            ex_rs_q        <= REG_ZERO;
            ex_rt_q        <= REG_ZERO;
            ex_dst_q       <= REG_ZERO;
            mem_tag_q      <= TAG_NONE;
            mem_dst_q      <= REG_ZERO;
            wb_valid_q     <= 1'b0;
            wb_reg_write_q <= 1'b0;
            wb_dst_q       <= REG_ZERO;
            ret_valid_q    <= 1'b0;
            ret_dst_q      <= REG_ZERO;
            ret_data_q     <= DATA_ZERO;
        end else begin
            state_q        <= state_d;
            ex_tag_q       <= ex_tag_d;
            ex_uses_rs_q   <= ex_uses_rs_d;
            ex_uses_rt_q   <= ex_uses_rt_d;
            ex_rs_q        <= ex_rs_d;
            ex_rt_q        <= ex_rt_d;
            ex_dst_q       <= ex_dst_d;
            mem_tag_q      <= mem_tag_d;
            mem_dst_q      <= mem_dst_d;
            wb_valid_q     <= wb_valid_d;
            wb_reg_write_q <= wb_reg_write_d;
            wb_dst_q       <= wb_dst_d;
            ret_valid_q    <= ret_valid_d;
            ret_dst_q      <= ret_dst_d;
            ret_data_q     <= ret_data_d;
        end
    end

    assign bus.stall  = stall;
    assign bus.bubble = stall;

    fwd_select #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .WB_BYPASS(WB_BYPASS)) u_sel_a (
        .ex_valid(ex_tag_q.valid), .uses(ex_uses_rs_q), .src(ex_rs_q),
        .mem_tag(mem_tag_q), .mem_dst(mem_dst_q),
        .wb_valid(wb_valid_q), .wb_reg_write(wb_reg_write_q), .wb_dst(wb_dst_q),
        .ret_valid(ret_valid_q), .ret_dst(ret_dst_q),
        .rf_data(bus.ex_rs_data), .exmem_data(bus.ex_mem_alu_result),
        .memwb_data(bus.mem_wb_write_data), .ret_data(ret_data_q),
        .sel(bus.forward_a), .operand(bus.operand_a)
    );

    fwd_select #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .WB_BYPASS(WB_BYPASS)) u_sel_b (
        .ex_valid(ex_tag_q.valid), .uses(ex_uses_rt_q), .src(ex_rt_q),
        .mem_tag(mem_tag_q), .mem_dst(mem_dst_q),
        .wb_valid(wb_valid_q), .wb_reg_write(wb_reg_write_q), .wb_dst(wb_dst_q),
        .ret_valid(ret_valid_q), .ret_dst(ret_dst_q),
        .rf_data(bus.ex_rt_data), .exmem_data(bus.ex_mem_alu_result),
        .memwb_data(bus.mem_wb_write_data), .ret_data(ret_data_q),
        .sel(bus.forward_b), .operand(bus.operand_b)
    );

endmodule

// File: doc/fwd_hazard_unit.md
Name: fwd_hazard_unit

Overview:
- Next-generation operand forwarding and load-use hazard controller for the 5-stage pipeline.
- Keeps its own shadow tag pipeline (EX, MEM, WB, RET) of destination and control bits, so the datapath only supplies decode-stage tags and bypass data.
- Produces independent forward selects for both ALU operands and the muxed operand values.
- Generates the load-use stall and bubble, honours a global hold and a branch flush, and adds a post-WB bypass so a register file read during its write stays correct.

Parameters:
- ADDR_W, 5, register address width; address 0 is hardwired zero.
- DATA_W, 32, operand width.
- WB_BYPASS, 1, 1 enables the RET forward source (select 2'b11); 0 never selects it.

Ports:
- clk  in  1  pipeline clock
- reset  in  1  synchronous, active-high
- hold  in  1  global freeze (e.g. cache miss): all internal state holds
- flush  in  1  branch taken: the instruction leaving ID is squashed
- id_valid  in  1  ID stage holds a real instruction
- id_rs, id_rt  in  ADDR_W  source registers of the ID instruction
- id_uses_rs, id_uses_rt  in  1  source is actually read
- id_reg_write, id_mem_read  in  1  ID instruction writes a register / is a load
- id_dst  in  ADDR_W  ID instruction destination
- ex_rs_data, ex_rt_data  in  DATA_W  register-file operands in ID/EX
- ex_mem_alu_result  in  DATA_W  EX/MEM ALU result
- mem_wb_write_data  in  DATA_W  final WB write value
- stall  out  1  hold PC and IF/ID
- bubble  out  1  load NOP into ID/EX
- forward_a, forward_b  out  2  00 regfile, 10 EX/MEM, 01 MEM/WB, 11 RET
- operand_a, operand_b  out  DATA_W  selected operands

Behaviour:
- Stage register fields: valid, rs, rt, uses_rs, uses_rt, reg_write, mem_read, dst, for EX, MEM and WB. RET holds valid, dst and data.
- Reset (synchronous): all stage valids are 0, the FSM is IDLE, and RET data is 0. With no valid stages, stall = 0, bubble = 0, forward_a = forward_b = 00, operand_a = ex_rs_data, operand_b = ex_rt_data.
- Load-use detect (combinational): id_valid & ex.valid & ex.mem_read & ex.dst != 0 & ((id_uses_rs & id_rs == ex.dst) | (id_uses_rt & id_rt == ex.dst)).
- FSM:
  - IDLE: if detect & !flush & !hold, then stall = 1, bubble = 1, and go to STALLED.
  - STALLED: stall = 0 and bubble = 0 unconditionally, so at most one stall cycle per load. Return to IDLE on the next non-hold edge.
  - hold freezes the FSM.
- Tag pipeline update on each edge:
  - reset: all valids are cleared.
  - hold: everything is unchanged.
  - otherwise, MEM <= EX, WB <= MEM, RET <= WB-derived values.
  - EX <= ID fields with valid = id_valid & !flush & !bubble.
  - flush and bubble in the same cycle: EX is invalid; flush wins and stall is forced to 0.
- RET update (non-hold):
  - valid <= wb.valid & wb.reg_write & wb.dst != 0.
  - dst <= wb.dst; data <= mem_wb_write_data.
- Forward select for operand A, evaluated against ex.rs and ex.uses_rs. Operand B is identical against rt, and the two are evaluated independently with no cross-suppression.
  - Every match also requires ex.valid, the source stage's reg_write, source dst != 0 and source dst == operand register.
  - 10 if MEM matches and !mem.mem_read.
  - else 01 if WB matches.
  - else 11 if WB_BYPASS and RET matches.
  - else 00.
  - If ex.valid = 0 or uses = 0, the select is 00.
- Operand mux: 10 gives ex_mem_alu_result, 01 gives mem_wb_write_data, 11 gives RET data, 00 gives the ex_*_data input. Purely combinational, zero latency.
- Invariant (bench assertion): a 10 select never occurs while mem.mem_read = 1.
- Reset mid-stall returns to IDLE with stall = 0 in the same edge.

Decomposition:
- Shared package pipe_pkg:
  - forward-select encodings FWD_RF = 2'b00, FWD_EXMEM = 2'b10, FWD_MEMWB = 2'b01, FWD_RET = 2'b11.
  - stage-tag struct type.
  - FSM state enum.
- Sub-module fwd_select: the combinational priority select plus mux for one operand, instantiated twice (A, B).

Test Plan:
- ALU chain: add r3 then sub r4, r3, r5 on consecutive cycles -> forward_a = 10 with operand_a = ex_mem_alu_result (0x0000_1234); forward_b = 00.
- Both operands hit different stages: r3 in MEM, r5 in WB, consumer add r6, r3, r5 -> forward_a = 10, forward_b = 01 in the same cycle.
- Load-use: lw r2 then add r7, r2, r1 -> exactly one cycle of stall = 1 and bubble = 1. The next cycle gives forward_a = 01 with operand_a = loaded data 0xDEAD_BEEF. No 10 select at any point.
- Register-file hazard: producer of r9 three instructions ahead, WB_BYPASS = 1 -> forward = 11 with RET data. With WB_BYPASS = 0 -> 00.
- r0 and priority: writes to r0 from MEM and WB -> select 00. MEM and WB both write r8 -> 10 wins.
- Control: flush coincident with load-use detect -> stall = 0 and EX invalid. Hold for 3 cycles mid-sequence -> selects and tags unchanged. Reset during STALLED -> stall = 0 and all selects 00 the next cycle.
